credential_store: RTL

- Credential memory that answers the login FSM's digit fetches on two independent read ports: ID_addr→ID_digit and pass_addr→pass_digit.
- Fixed 2-cycle read latency, matching the controller's two-cycle Cycle wait.
- Also contains the writer side: a keypad enrollment FSM that captures a new 4-digit ID and 6-digit password for a player slot and commits them atomically.
- Sits between the keypad/debounce logic and the access controller.

---
 rtl/cred_pkg.sv | 44 ++++
 rtl/cred_read_port.sv | 53 +++++
 rtl/credential_store.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cred_pkg.sv
// Shared definitions for the credential store: slot geometry, address
// field layout, enrollment state encoding and the reset-default contents.
package cred_pkg;

   localparam int NUM_SLOTS  = 4;
   localparam int GUEST_SLOT = 3;
   localparam int ID_LEN     = 4;
   localparam int PW_LEN     = 6;

   // Fetch address layout: {digit[5:3], slot[2:0]}
   localparam int ADDR_W    = 6;
   localparam int SLOT_LSB  = 0;
   localparam int SLOT_MSB  = 2;
   localparam int DIGIT_LSB = 3;
   localparam int DIGIT_MSB = 5;

   // Width of a latched, already range-checked slot index
   localparam int SLOT_IDX_W = 2;

   localparam logic [3:0] INVALID_DIGIT = 4'hF;
   localparam logic [3:0] MAX_BCD       = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ID_ENTRY,
      ST_PW_ENTRY,
      ST_CHECK,
      ST_COMMIT
   } enrollState_e;

   // Default ID for slot s is 0,0,0,s (index 0 first)
   function automatic logic [3:0] defaultIdDigit(input int slot, input int idx);
      if (idx == ID_LEN - 1) begin
         return 4'(slot);
      end
      return 4'd0;
   endfunction

   // Default password for slot s is s repeated in every position
   function automatic logic [3:0] defaultPwDigit(input int slot);
      return 4'(slot);
   endfunction

endpackage

// File: rtl/cred_read_port.sv
// One read port of the credential store: a two-stage pipe (address register,
// then data register) with a range check that returns INVALID_DIGIT for any
// slot or digit outside the stored array.
module cred_read_port
   import cred_pkg::*;
#(
   parameter int DIGIT_LEN = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [ADDR_W-1:0]                 addr_i,
   input  logic [NUM_SLOTS*DIGIT_LEN*4-1:0]  memFlat_i,
   output logic [3:0]                        digit_o
);

   localparam int FLAT_W = NUM_SLOTS * DIGIT_LEN * 4;
   localparam int IDX_W  = $clog2(FLAT_W);

   logic [ADDR_W-1:0] addrQ;
   logic [3:0]        dataQ;
   logic [3:0]        lookupData;
   logic [2:0]        slotField;
   logic [2:0]        digitField;
   logic [IDX_W-1:0]  bitIdx;

   // Decode the registered address and pick the addressed digit, or the
   // invalid marker when the slot or digit lies outside the array
   always_comb begin
      lookupData = INVALID_DIGIT;
      slotField  = addrQ[SLOT_MSB:SLOT_LSB];
      digitField = addrQ[DIGIT_MSB:DIGIT_LSB];
      bitIdx     = '0;
      if ((int'(slotField) < NUM_SLOTS) && (int'(digitField) < DIGIT_LEN)) begin
         bitIdx     = IDX_W'((int'(slotField) * DIGIT_LEN + int'(digitField)) * 4);
         lookupData = memFlat_i[bitIdx +: 4];
      end
   end

   // First edge captures the address, second edge captures the array word,
   // so the array is sampled at the data-register edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addrQ <= '0;
         dataQ <= '0;
      end else begin
         addrQ <= addr_i;
         dataQ <= lookupData;
      end
   end

   assign digit_o = dataQ;

endmodule

// File: rtl/credential_store.sv
// Credential store: register-array ID/password memory with two independent
// 2-cycle read ports, plus the keypad enrollment FSM that shadows a new
// 4-digit ID and 6-digit password and commits all ten digits in one edge.
module credential_store
   import cred_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  ID_addr,
   input  logic [5:0]  pass_addr,
   output logic [3:0]  ID_digit,
   output logic [3:0]  pass_digit,
   input  logic        enroll_start,
   input  logic [2:0]  enroll_slot,
   input  logic        enroll_abort,
   input  logic        load,
   input  logic [3:0]  input_data,
   output logic        enroll_busy,
   output logic        enroll_done,
   output logic        enroll_error
);

   logic [3:0] idMemQ [NUM_SLOTS][ID_LEN];
   logic [3:0] pwMemQ [NUM_SLOTS][PW_LEN];

   logic [NUM_SLOTS*ID_LEN*4-1:0] idFlat;
   logic [NUM_SLOTS*PW_LEN*4-1:0] pwFlat;

   enrollState_e          stateQ, stateD;
   logic [SLOT_IDX_W-1:0] slotQ, slotD;
   logic [2:0]            countQ, countD;
   logic [3:0]            idShadowQ [ID_LEN];
   logic [3:0]            idShadowD [ID_LEN];
   logic [3:0]            pwShadowQ [PW_LEN];
   logic [3:0]            pwShadowD [PW_LEN];
   logic                  busyQ, busyD;
   logic                  doneQ, doneD;
   logic                  errorQ, errorD;
   logic                  commitEn;
   logic                  dupFound;
   logic                  slotMatch;

   // Present the arrays to the read ports as flat vectors
   for (genvar s = 0; s < NUM_SLOTS; s++) begin : gFlatSlot
      for (genvar d = 0; d < ID_LEN; d++) begin : gFlatId
         assign idFlat[(s*ID_LEN+d)*4 +: 4] = idMemQ[s][d];
      end
      for (genvar d = 0; d < PW_LEN; d++) begin : gFlatPw
         assign pwFlat[(s*PW_LEN+d)*4 +: 4] = pwMemQ[s][d];
      end
   end

   cred_read_port #(.DIGIT_LEN(ID_LEN)) uIdPort (
      .clk       (clk),
      .reset     (reset),
      .addr_i    (ID_addr),
      .memFlat_i (idFlat),
      .digit_o   (ID_digit)
   );

   cred_read_port #(.DIGIT_LEN(PW_LEN)) uPassPort (
      .clk       (clk),
      .reset     (reset),
      .addr_i    (pass_addr),
      .memFlat_i (pwFlat),
      .digit_o   (pass_digit)
   );

   // Look for the shadow ID in every slot other than the target, guest included
   always_comb begin
      dupFound  = 1'b0;
      slotMatch = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         slotMatch = 1'b1;
         for (int d = 0; d < ID_LEN; d++) begin
            if (idMemQ[s][d] != idShadowQ[d]) begin
               slotMatch = 1'b0;
            end
         end
         if (slotMatch && (SLOT_IDX_W'(s) != slotQ)) begin
            dupFound = 1'b1;
         end
      end
   end

   // Enrollment next-state logic; any return to IDLE discards the shadows
   always_comb begin
      stateD    = stateQ;
      slotD     = slotQ;
      countD    = countQ;
      idShadowD = idShadowQ;
      pwShadowD = pwShadowQ;
      doneD     = 1'b0;
      errorD    = 1'b0;
      commitEn  = 1'b0;

      case (stateQ)
         ST_IDLE: begin
            if (enroll_start) begin
               if ((enroll_slot >= 3'(NUM_SLOTS)) || (enroll_slot == 3'(GUEST_SLOT))) begin
                  errorD = 1'b1;
               end else begin
                  slotD  = enroll_slot[SLOT_IDX_W-1:0];
                  countD = 3'd0;
                  stateD = ST_ID_ENTRY;
               end
            end
         end
         ST_ID_ENTRY: begin
            if (enroll_abort) begin
               stateD = ST_IDLE;
            end else if (load) begin
               if (input_data > MAX_BCD) begin
                  errorD = 1'b1;
                  stateD = ST_IDLE;
               end else begin
                  idShadowD[countQ[1:0]] = input_data;
                  if (countQ == 3'(ID_LEN - 1)) begin
                     countD = 3'd0;
                     stateD = ST_PW_ENTRY;
                  end else begin
                     countD = countQ + 3'd1;
                  end
               end
            end
         end
         ST_PW_ENTRY: begin
            if (enroll_abort) begin
               stateD = ST_IDLE;
            end else if (load) begin
               if (input_data > MAX_BCD) begin
                  errorD = 1'b1;
                  stateD = ST_IDLE;
               end else begin
                  pwShadowD[countQ] = input_data;
                  if (countQ == 3'(PW_LEN - 1)) begin
                     countD = 3'd0;
                     stateD = ST_CHECK;
                  end else begin
                     countD = countQ + 3'd1;
                  end
               end
            end
         end
         ST_CHECK: begin
            if (enroll_abort) begin
               stateD = ST_IDLE;
            end else if (dupFound) begin
               errorD = 1'b1;
               stateD = ST_IDLE;
            end else begin
               stateD = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            if (enroll_abort) begin
               stateD = ST_IDLE;
            end else begin
               commitEn = 1'b1;
               doneD    = 1'b1;
               stateD   = ST_IDLE;
            end
         end
         default: begin
            stateD = ST_IDLE;
         end
      endcase

      if (stateD == ST_IDLE) begin
         countD    = 3'd0;
         idShadowD = '{default: '0};
         pwShadowD = '{default: '0};
      end

      busyD = (stateD != ST_IDLE);
   end

   // Enrollment state, shadow buffers and registered status pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ    <= ST_IDLE;
         slotQ     <= '0;
         countQ    <= '0;
         idShadowQ <= '{default: '0};
         pwShadowQ <= '{default: '0};
         busyQ     <= 1'b0;
         doneQ     <= 1'b0;
         errorQ    <= 1'b0;
      end else begin
         stateQ    <= stateD;
         slotQ     <= slotD;
         countQ    <= countD;
         idShadowQ <= idShadowD;
         pwShadowQ <= pwShadowD;
         busyQ     <= busyD;
         doneQ     <= doneD;
         errorQ    <= errorD;
      end
   end

   // Credential arrays: defaults on reset, all ten digits written in one commit edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int d = 0; d < ID_LEN; d++) begin
               idMemQ[s][d] <= defaultIdDigit(s, d);
            end
            for (int d = 0; d < PW_LEN; d++) begin
               pwMemQ[s][d] <= defaultPwDigit(s);
            end
         end
      end else if (commitEn) begin
         for (int d = 0; d < ID_LEN; d++) begin
            idMemQ[slotQ][d] <= idShadowQ[d];
         end
         for (int d = 0; d < PW_LEN; d++) begin
            pwMemQ[slotQ][d] <= pwShadowQ[d];
         end
      end
   end

   assign enroll_busy  = busyQ;
   assign enroll_done  = doneQ;
   assign enroll_error = errorQ;

endmodule
